// File: rtl/glyph_loader_if.sv
// Byte-stream and glyph-store write bundle for glyph_loader.
//   byte_data/byte_valid/byte_ready : host link byte stream (valid/ready)
//   mem_write/mem_x/mem_y/mem_data  : one-pixel-per-cycle store write port
//   busy/done/err                   : loader status
// slave  = the loader side, master = the link/store side.
interface glyph_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       mem_write;
    logic [1:0] mem_x;
    logic [2:0] mem_y;
    logic       mem_data;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, mem_write, mem_x, mem_y, mem_data, busy, done, err
    );

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, mem_write, mem_x, mem_y, mem_data, busy, done, err
    );
endinterface

// File: rtl/glyph_loader.sv
// glyph_loader: receives a framed glyph (HEADER + 3 payload bytes) and writes
// its 20 pixel bits into the 4x5 glyph store, one bit per cycle.
//   clock : system clock, all logic on posedge
//   rst   : asynchronous active-high reset
//   bus   : glyph_loader_if.slave (byte stream in, store write + status out)
// Glyph layout: bit k sits at column k%4, row k/4; payload byte 0 supplies
// bits 19:16 (its high nibble is ignored), byte 1 bits 15:8, byte 2 bits 7:0.
module glyph_loader #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000   // 0 disables the timeout
) (
    input  logic           clock,
    input  logic           rst,
    glyph_loader_if.slave  bus
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t        state, state_n;
    logic [19:0]   glyph, glyph_n;
    logic [1:0]    bcnt, bcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [4:0]    k, k_n;

    logic          mem_write_q, mem_write_n;
    logic [1:0]    mem_x_q, mem_x_n;
    logic [2:0]    mem_y_q, mem_y_n;
    logic          mem_data_q, mem_data_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          err_q, err_n;

    logic          accept;

    assign bus.byte_ready = (state == IDLE) || (state == RECV);
    assign accept         = bus.byte_valid && bus.byte_ready;

    assign bus.mem_write = mem_write_q;
    assign bus.mem_x     = mem_x_q;
    assign bus.mem_y     = mem_y_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            glyph       <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            k           <= '0;
            mem_write_q <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            mem_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            glyph       <= glyph_n;
            bcnt        <= bcnt_n;
            tcnt        <= tcnt_n;
            k           <= k_n;
            mem_write_q <= mem_write_n;
            mem_x_q     <= mem_x_n;
            mem_y_q     <= mem_y_n;
            mem_data_q  <= mem_data_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            err_q       <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        glyph_n    = glyph;
        bcnt_n     = bcnt;
        tcnt_n     = tcnt;
        k_n        = k;
        err_n      = 1'b0;
        mem_x_n    = mem_x_q;
        mem_y_n    = mem_y_q;
        mem_data_n = mem_data_q;

        case (state)
            IDLE: begin
                if (accept && bus.byte_data == HEADER) begin
                    state_n = RECV;
                    bcnt_n  = '0;
                    tcnt_n  = '0;
                end
            end
            RECV: begin
                // An accepted byte takes priority over a timeout on the same edge.
                if (accept) begin
                    tcnt_n = '0;
                    case (bcnt)
                        2'd0: begin
                            glyph_n[19:16] = bus.byte_data[3:0];
                            bcnt_n         = 2'd1;
                        end
                        2'd1: begin
                            glyph_n[15:8] = bus.byte_data;
                            bcnt_n        = 2'd2;
                        end
                        default: begin
                            glyph_n[7:0] = bus.byte_data;
                            bcnt_n       = 2'd0;
                            state_n      = WRITE;
                            k_n          = '0;
                        end
                    endcase
                end else if (TIMEOUT_CYC != 0 && tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Silent cycle count reaches TIMEOUT_CYC on this edge.
                    state_n = IDLE;
                    err_n   = 1'b1;
                    bcnt_n  = '0;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            WRITE: begin
                if (k == 5'd19) state_n = DONE;
                else            k_n     = k + 5'd1;
            end
            default: state_n = IDLE;   // DONE
        endcase

        // Outputs are registered: they are computed from the next state so the
        // write for pixel k is visible during the cycle the FSM spends on k.
        mem_write_n = (state_n == WRITE);
        if (mem_write_n) begin
            mem_x_n    = k_n[1:0];
            mem_y_n    = k_n[4:2];
            mem_data_n = glyph_n[k_n];
        end
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_glyph_loader.sv
// Self-checking bench for glyph_loader: schedule-based reference model,
// per-cycle output comparison, directed frames plus 200 random glyphs.
module tb_glyph_loader;
    localparam int TIMEOUT = 1000;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    glyph_loader_if bus();

    glyph_loader dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Interval n = the cycle following the n-th non-reset posedge.
    // A completed frame schedules writes in intervals ws..ws+19, done at ws+20;
    // byte_ready is low over ws..ws+20.
    int          n      = 0;
    int          mb     = -1;     // payload bytes collected, -1 = hunting header
    int          msil   = 0;      // silent cycles while collecting
    logic [19:0] mg     = '0;     // glyph being collected / written
    int          ws     = -1000;
    int          err_at = -1000;
    bit          wrote  = 0;
    logic [19:0] exp_store = '0;
    logic [19:0] dut_store = '0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;

    function automatic bit m_ready(input int i);
        return !(i >= ws && i <= ws + 20);
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            mb = -1; msil = 0; ws = -1000; err_at = -1000; wrote = 0;
        end else begin
            bit acc;
            n++;
            acc = bus.byte_valid && m_ready(n - 1);
            if (mb < 0) begin
                if (acc && bus.byte_data == 8'hA5) begin
                    mb = 0; msil = 0;
                end
            end else if (acc) begin
                if (mb == 0)      mg[19:16] = bus.byte_data[3:0];
                else if (mb == 1) mg[15:8]  = bus.byte_data;
                else              mg[7:0]   = bus.byte_data;
                mb++;
                msil = 0;
                if (mb == 3) begin
                    ws = n; wrote = 1; mb = -1;
                end
            end else begin
                msil++;
                if (msil == TIMEOUT) begin
                    err_at = n; mb = -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (rst) begin
            chk("rst_ready", bus.byte_ready, 1);
            chk("rst_write", bus.mem_write, 0);
            chk("rst_x",     bus.mem_x, 0);
            chk("rst_y",     bus.mem_y, 0);
            chk("rst_data",  bus.mem_data, 0);
            chk("rst_busy",  bus.busy, 0);
            chk("rst_done",  bus.done, 0);
            chk("rst_err",   bus.err, 0);
        end else begin
            bit ew;
            int kk;
            ew = (n >= ws && n <= ws + 19);
            kk = n - ws;
            chk("byte_ready", bus.byte_ready, m_ready(n));
            chk("mem_write",  bus.mem_write, ew);
            chk("busy",       bus.busy, (mb >= 0) || (n >= ws && n <= ws + 20));
            chk("done",       bus.done, n == ws + 20);
            chk("err",        bus.err, n == err_at);
            chk("mem_x",      bus.mem_x, ew ? kk % 4 : (wrote ? 3 : 0));
            chk("mem_y",      bus.mem_y, ew ? kk / 4 : (wrote ? 4 : 0));
            if (ew) begin
                chk("mem_data", bus.mem_data, mg[kk]);
                exp_store[kk] = mg[kk];
            end
            if (bus.mem_write) begin
                if (bus.mem_y > 3'd4) chk("mem_y_range", bus.mem_y, 4);
                else dut_store[int'(bus.mem_y) * 4 + int'(bus.mem_x)] = bus.mem_data;
            end
            if (bus.done) done_cnt++;
            if (bus.err)  err_cnt++;
            if (n == ws + 20) chk("store", dut_store, exp_store);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.byte_ready) begin
                @(posedge clock);
                #1;
                bus.byte_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nlow, output int nwr);
        cyc = 0; nlow = 0; nwr = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (!bus.byte_ready) nlow++;
            if (bus.mem_write)   nwr++;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int cyc, nlow, nwr, d0, e0;
        logic [7:0]  b0, b1, b2, j;
        logic [19:0] g;

        bus.byte_data  = '0;
        bus.byte_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // 1: back-to-back frame
        send(8'hA5); send(8'h0F); send(8'hFF); send(8'h00);
        wait_done(cyc, nlow, nwr);
        chk("t1_done_lat",  cyc, 21);
        chk("t1_ready_low", nlow, 21);
        chk("t1_writes",    nwr, 20);
        chk("t1_glyph",     dut_store, 20'hFFF00);
        chk("t1_model",     mg, 20'hFFF00);
        idle(2);

        // 2: junk before header, header value as payload
        send(8'h00); send(8'h3C); send(8'hA5); send(8'h05); send(8'hA5); send(8'h5A);
        wait_done(cyc, nlow, nwr);
        chk("t2_glyph", dut_store, 20'h5A55A);
        chk("t2_model", mg, 20'h5A55A);
        idle(2);

        // 3: timeout after one payload byte
        e0 = err_cnt;
        send(8'hA5); send(8'h01);
        nwr = 0;
        repeat (1010) begin
            @(negedge clock);
            if (bus.mem_write) nwr++;
        end
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_writes",     nwr, 0);
        chk("t3_busy",       bus.busy, 0);
        idle(1);
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56);
        wait_done(cyc, nlow, nwr);
        chk("t3_glyph", dut_store, 20'h23456);
        idle(2);

        // 4: valid held with 77 during WRITE
        send(8'hA5); send(8'h0C); send(8'hDE); send(8'hF0);
        bus.byte_data  = 8'h77;
        bus.byte_valid = 1'b1;
        wait_done(cyc, nlow, nwr);
        bus.byte_valid = 1'b0;
        chk("t4_writes", nwr, 20);
        chk("t4_glyph",  dut_store, 20'hCDEF0);
        idle(2);

        // 5: reset at k=10
        d0 = done_cnt;
        send(8'hA5); send(8'h0B); send(8'h77); send(8'h99);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.mem_write && bus.mem_x == 2'd2 && bus.mem_y == 3'd2) begin
                cyc = 1;
                break;
            end
        end
        chk("t5_reached_k10", cyc, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_write_drop", bus.mem_write, 0);
        chk("t5_busy",       bus.busy, 0);
        chk("t5_ready",      bus.byte_ready, 1);
        @(posedge clock);
        #1 rst = 1'b0;
        idle(30);
        chk("t5_no_done", done_cnt - d0, 0);

        // 6: random glyphs with random junk and gaps
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                send(j);
            end
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            g  = {b0[3:0], b1, b2};
            send(8'hA5);
            idle($urandom_range(0, 3));
            send(b0);
            idle($urandom_range(0, 3));
            send(b1);
            idle($urandom_range(0, 3));
            send(b2);
            wait_done(cyc, nlow, nwr);
            chk("t6_glyph", dut_store, g);
            idle($urandom_range(0, 3));
        end

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
